// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: entry lifecycle, op kinds and default sizes
// used by the commit buffer, rob and regfile.
package tomasulo_pkg;

  localparam int ROB_DEPTH = 4;
  localparam int DATA_W    = 64;
  localparam int REG_W     = 5;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ISSUED = 2'd1,
    DONE   = 2'd2
  } entry_state_t;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_BRANCH = 2'd2
  } kind_t;

endpackage

// File: rtl/commit_entry.sv
// One commit buffer slot: lifecycle state plus the payload captured at
// allocation (dest, kind) and at CDB completion (data, addr, mispredict).
// Only the state is reset; the payload is meaningless while the slot is EMPTY.
module commit_entry
  import tomasulo_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          clear,
  input  logic          alloc_en,
  input  logic [4:0]    alloc_dest,
  input  logic [1:0]    alloc_kind,
  input  logic          cdb_en,
  input  logic [DW-1:0] cdb_data,
  input  logic [DW-1:0] cdb_addr,
  input  logic          cdb_mispredict,
  output logic [1:0]    state,
  output logic [4:0]    dest,
  output logic [1:0]    kind,
  output logic [DW-1:0] data,
  output logic [DW-1:0] addr,
  output logic          mispredict
);

  entry_state_t  state_q, state_d;
  logic [4:0]    dest_q, dest_d;
  logic [1:0]    kind_q, kind_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] addr_q, addr_d;
  logic          mispred_q, mispred_d;
  logic          cdb_hit;

  // A broadcast only completes a slot that is waiting on it
  assign cdb_hit = cdb_en && (state_q == ISSUED);

  // Lifecycle: retirement/squash beats allocation beats completion
  always_comb begin
    state_d = state_q;
    if (flush || clear) begin
      state_d = EMPTY;
    end else if (alloc_en) begin
      state_d = ISSUED;
    end else if (cdb_hit) begin
      state_d = DONE;
    end
  end

  // Lifecycle state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload capture on allocation and on completion
  always_comb begin
    dest_d    = dest_q;
    kind_d    = kind_q;
    data_d    = data_q;
    addr_d    = addr_q;
    mispred_d = mispred_q;
    if (alloc_en) begin
      dest_d = alloc_dest;
      kind_d = alloc_kind;
    end
    if (cdb_hit) begin
      data_d    = cdb_data;
      addr_d    = cdb_addr;
      mispred_d = cdb_mispredict;
    end
  end

  // Payload registers
  always_ff @(posedge clk) begin
    dest_q    <= dest_d;
    kind_q    <= kind_d;
    data_q    <= data_d;
    addr_q    <= addr_d;
    mispred_q <= mispred_d;
  end

  assign state      = state_q;
  assign dest       = dest_q;
  assign kind       = kind_q;
  assign data       = data_q;
  assign addr       = addr_q;
  assign mispredict = mispred_q;

endmodule

// File: rtl/commit_buffer.sv
// In-order retirement buffer for the CDB protocol. Issue allocates slots at
// the tail, the CDB completes them in any order, and the head retires at most
// one per cycle to the regfile (reg ops) or memory (stores). A mispredicted
// branch retires and then squashes everything younger.
// Build option: COMMIT_BYPASS_EN lets a CDB completion of the head slot
// retire in the same cycle instead of first landing in DONE.
module commit_buffer
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int DW    = DATA_W,
  localparam int SW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  input  logic [4:0]    alloc_dest,
  input  logic [1:0]    alloc_kind,
  output logic [SW-1:0] alloc_slot,
  output logic          full,
  input  logic          cdb_valid,
  input  logic [SW-1:0] cdb_rob_slot,
  input  logic [DW-1:0] cdb_data,
  input  logic [DW-1:0] cdb_addr,
  input  logic          cdb_mispredict,
  output logic          commit_valid,
  output logic [4:0]    commit_dest,
  output logic [DW-1:0] commit_data,
  output logic [SW-1:0] commit_slot,
  output logic          st_commit,
  output logic [DW-1:0] st_addr,
  output logic [DW-1:0] st_data,
  output logic          flush,
  output logic          cdb_err
);

  localparam logic [SW:0]   CNT_FULL = (SW+1)'(DEPTH);
  localparam logic [SW:0]   CNT_ONE  = (SW+1)'(1);
  localparam logic [SW-1:0] PTR_ONE  = SW'(1);

  logic [SW-1:0] head_q, head_d, tail_q, tail_d;
  logic [SW:0]   count_q, count_d;

  logic [1:0]    ent_state   [DEPTH];
  logic [4:0]    ent_dest    [DEPTH];
  logic [1:0]    ent_kind    [DEPTH];
  logic [DW-1:0] ent_data    [DEPTH];
  logic [DW-1:0] ent_addr    [DEPTH];
  logic          ent_mispred [DEPTH];
  logic [DEPTH-1:0] ent_alloc, ent_cdb, ent_clear;

  logic          full_w, alloc_ok, cdb_live, byp, retire, squash;
  logic [4:0]    r_dest;
  logic [1:0]    r_kind;
  logic [DW-1:0] r_data, r_addr;
  logic          r_mispred;

  logic          commit_valid_q, commit_valid_d;
  logic [4:0]    commit_dest_q, commit_dest_d;
  logic [DW-1:0] commit_data_q, commit_data_d;
  logic [SW-1:0] commit_slot_q, commit_slot_d;
  logic          st_commit_q, st_commit_d;
  logic [DW-1:0] st_addr_q, st_addr_d;
  logic [DW-1:0] st_data_q, st_data_d;
  logic          flush_q, flush_d;
  logic          cdb_err_q, cdb_err_d;

  // Full uses the registered count, so a same-cycle retirement never frees a
  // slot for allocation. The flush cycle drops both allocation and the CDB.
  assign full_w   = (count_q == CNT_FULL);
  assign alloc_ok = alloc_valid && !full_w && !flush_q;
  assign cdb_live = cdb_valid && !flush_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_alloc[i] = alloc_ok && (tail_q == SW'(i));
    assign ent_cdb[i]   = cdb_live && (cdb_rob_slot == SW'(i));
    assign ent_clear[i] = retire && (head_q == SW'(i));

    commit_entry #(.DW(DW)) u_entry (
      .clk            (clk),
      .rst            (rst),
      .flush          (squash),
      .clear          (ent_clear[i]),
      .alloc_en       (ent_alloc[i]),
      .alloc_dest     (alloc_dest),
      .alloc_kind     (alloc_kind),
      .cdb_en         (ent_cdb[i]),
      .cdb_data       (cdb_data),
      .cdb_addr       (cdb_addr),
      .cdb_mispredict (cdb_mispredict),
      .state          (ent_state[i]),
      .dest           (ent_dest[i]),
      .kind           (ent_kind[i]),
      .data           (ent_data[i]),
      .addr           (ent_addr[i]),
      .mispredict     (ent_mispred[i])
    );
  end

  // Head retirement decision; the bypass path takes completion fields
  // straight from the bus when the head is being completed this cycle
  always_comb begin
    byp = 1'b0;
`ifdef COMMIT_BYPASS_EN
    byp = cdb_live && (cdb_rob_slot == head_q) && (ent_state[head_q] == ISSUED);
`endif
    retire    = (ent_state[head_q] == DONE) || byp;
    r_dest    = ent_dest[head_q];
    r_kind    = ent_kind[head_q];
    r_data    = byp ? cdb_data       : ent_data[head_q];
    r_addr    = byp ? cdb_addr       : ent_addr[head_q];
    r_mispred = byp ? cdb_mispredict : ent_mispred[head_q];
    squash    = retire && (r_kind == KIND_BRANCH) && r_mispred;
  end

  // Pointer and occupancy update; a squash empties the whole buffer
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_ok) tail_d = tail_q + PTR_ONE;
      if (retire)   head_d = head_q + PTR_ONE;
      if (alloc_ok && !retire) count_d = count_q + CNT_ONE;
      else if (!alloc_ok && retire) count_d = count_q - CNT_ONE;
    end
  end

  // Registered retirement outputs, flush pulse and sticky CDB error
  always_comb begin
    commit_valid_d = retire && (r_kind == KIND_REG);
    st_commit_d    = retire && (r_kind == KIND_STORE);
    flush_d        = squash;
    commit_dest_d  = commit_dest_q;
    commit_data_d  = commit_data_q;
    commit_slot_d  = commit_slot_q;
    st_addr_d      = st_addr_q;
    st_data_d      = st_data_q;
    if (commit_valid_d) begin
      commit_dest_d = r_dest;
      commit_data_d = r_data;
      commit_slot_d = head_q;
    end
    if (st_commit_d) begin
      st_addr_d = r_addr;
      st_data_d = r_data;
    end
    cdb_err_d = cdb_err_q || (cdb_live && (ent_state[cdb_rob_slot] != ISSUED));
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_dest_q  <= '0;
      commit_data_q  <= '0;
      commit_slot_q  <= '0;
      st_commit_q    <= 1'b0;
      st_addr_q      <= '0;
      st_data_q      <= '0;
      flush_q        <= 1'b0;
      cdb_err_q      <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_dest_q  <= commit_dest_d;
      commit_data_q  <= commit_data_d;
      commit_slot_q  <= commit_slot_d;
      st_commit_q    <= st_commit_d;
      st_addr_q      <= st_addr_d;
      st_data_q      <= st_data_d;
      flush_q        <= flush_d;
      cdb_err_q      <= cdb_err_d;
    end
  end

  assign alloc_slot   = tail_q;
  assign full         = full_w;
  assign commit_valid = commit_valid_q;
  assign commit_dest  = commit_dest_q;
  assign commit_data  = commit_data_q;
  assign commit_slot  = commit_slot_q;
  assign st_commit    = st_commit_q;
  assign st_addr      = st_addr_q;
  assign st_data      = st_data_q;
  assign flush        = flush_q;
  assign cdb_err      = cdb_err_q;

endmodule

// File: tb/tb_commit_buffer.sv
// Directed bench for commit_buffer: one task per scenario with inline checks.
module tb_commit_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 64;
  localparam int SW    = 2;
`ifdef COMMIT_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk, rst;
  logic          alloc_valid;
  logic [4:0]    alloc_dest;
  logic [1:0]    alloc_kind;
  logic [SW-1:0] alloc_slot;
  logic          full;
  logic          cdb_valid;
  logic [SW-1:0] cdb_rob_slot;
  logic [DW-1:0] cdb_data, cdb_addr;
  logic          cdb_mispredict;
  logic          commit_valid;
  logic [4:0]    commit_dest;
  logic [DW-1:0] commit_data;
  logic [SW-1:0] commit_slot;
  logic          st_commit;
  logic [DW-1:0] st_addr, st_data;
  logic          flush, cdb_err;

  int vectors = 0;
  int miscompares = 0;

  commit_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_kind(alloc_kind),
    .alloc_slot(alloc_slot), .full(full),
    .cdb_valid(cdb_valid), .cdb_rob_slot(cdb_rob_slot), .cdb_data(cdb_data),
    .cdb_addr(cdb_addr), .cdb_mispredict(cdb_mispredict),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_data(commit_data),
    .commit_slot(commit_slot), .st_commit(st_commit), .st_addr(st_addr), .st_data(st_data),
    .flush(flush), .cdb_err(cdb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] d, input logic [1:0] k);
    alloc_valid = 1'b1; alloc_dest = d; alloc_kind = k;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic cdb_send(input logic [SW-1:0] s, input logic [DW-1:0] d,
                          input logic [DW-1:0] a, input logic m);
    cdb_valid = 1'b1; cdb_rob_slot = s; cdb_data = d; cdb_addr = a; cdb_mispredict = m;
    tick();
    cdb_valid = 1'b0; cdb_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({commit_valid, commit_dest, commit_data, commit_slot, st_commit, st_addr, st_data,
         flush, cdb_err, full, alloc_slot} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got cv=%0b st=%0b fl=%0b err=%0b full=%0b slot=%0d exp all 0",
               commit_valid, st_commit, flush, cdb_err, full, alloc_slot);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    vectors++;
    if (alloc_slot !== 2'd0) begin
      miscompares++; $display("FAIL basic_alloc_slot got %0d exp 0", alloc_slot);
    end
    alloc(5'd3, 2'd0);
    cdb_send(2'd0, 64'h2A, 64'h0, 1'b0);
    repeat (LAT-1) tick();
    vectors++;
    if ({commit_valid, commit_dest, commit_data, commit_slot} !== {1'b1, 5'd3, 64'h2A, 2'd0}) begin
      miscompares++;
      $display("FAIL basic_commit got v=%0b d=%0d data=%0h s=%0d exp v=1 d=3 data=2a s=0",
               commit_valid, commit_dest, commit_data, commit_slot);
    end
    vectors++;
    if (dut.count_q !== 3'd0) begin
      miscompares++; $display("FAIL basic_count got %0d exp 0", dut.count_q);
    end
    tick();
    vectors++;
    if (commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_pulse_end got %0b exp 0", commit_valid);
    end
  endtask

  task automatic test_order();
    do_reset();
    alloc(5'd5, 2'd0);
    alloc(5'd6, 2'd0);
    alloc(5'd7, 2'd0);
    cdb_send(2'd2, 64'hC, 64'h0, 1'b0);
    vectors++;
    if (commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL order_early_c got %0b exp 0", commit_valid);
    end
    cdb_send(2'd1, 64'hB, 64'h0, 1'b0);
    vectors++;
    if (commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL order_early_b got %0b exp 0", commit_valid);
    end
    cdb_send(2'd0, 64'hA, 64'h0, 1'b0);
    repeat (LAT-1) tick();
    vectors++;
    if ({commit_valid, commit_dest, commit_data} !== {1'b1, 5'd5, 64'hA}) begin
      miscompares++;
      $display("FAIL order_a got v=%0b d=%0d data=%0h exp v=1 d=5 data=a",
               commit_valid, commit_dest, commit_data);
    end
    tick();
    vectors++;
    if ({commit_valid, commit_dest, commit_data} !== {1'b1, 5'd6, 64'hB}) begin
      miscompares++;
      $display("FAIL order_b got v=%0b d=%0d data=%0h exp v=1 d=6 data=b",
               commit_valid, commit_dest, commit_data);
    end
    tick();
    vectors++;
    if ({commit_valid, commit_dest, commit_data, commit_slot} !== {1'b1, 5'd7, 64'hC, 2'd2}) begin
      miscompares++;
      $display("FAIL order_c got v=%0b d=%0d data=%0h s=%0d exp v=1 d=7 data=c s=2",
               commit_valid, commit_dest, commit_data, commit_slot);
    end
    tick();
    vectors++;
    if (commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL order_drained got %0b exp 0", commit_valid);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) alloc(5'(i), 2'd0);
    vectors++;
    if ({full, alloc_slot} !== {1'b1, 2'd0}) begin
      miscompares++; $display("FAIL full_set got full=%0b slot=%0d exp full=1 slot=0", full, alloc_slot);
    end
    alloc(5'd9, 2'd0);
    vectors++;
    if ({full, dut.count_q} !== {1'b1, 3'd4}) begin
      miscompares++;
      $display("FAIL full_drop got full=%0b count=%0d exp full=1 count=4", full, dut.count_q);
    end
    alloc_valid = 1'b1; alloc_dest = 5'd10; alloc_kind = 2'd0;
    cdb_send(2'd0, 64'h55, 64'h0, 1'b0);
    repeat (LAT-1) tick();
    alloc_valid = 1'b0;
    vectors++;
    if ({commit_valid, commit_dest, commit_data} !== {1'b1, 5'd1, 64'h55}) begin
      miscompares++;
      $display("FAIL full_commit got v=%0b d=%0d data=%0h exp v=1 d=1 data=55",
               commit_valid, commit_dest, commit_data);
    end
    vectors++;
    if ({dut.count_q, full, alloc_slot} !== {3'd3, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL full_same_cycle got count=%0d full=%0b slot=%0d exp count=3 full=0 slot=0",
               dut.count_q, full, alloc_slot);
    end
  endtask

  task automatic test_store();
    do_reset();
    alloc(5'd0, 2'd1);
    cdb_send(2'd0, 64'hDEAD, 64'h100, 1'b0);
    repeat (LAT-1) tick();
    vectors++;
    if ({st_commit, st_addr, st_data, commit_valid} !== {1'b1, 64'h100, 64'hDEAD, 1'b0}) begin
      miscompares++;
      $display("FAIL store got st=%0b addr=%0h data=%0h cv=%0b exp st=1 addr=100 data=dead cv=0",
               st_commit, st_addr, st_data, commit_valid);
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    alloc(5'd0, 2'd2);
    alloc(5'd8, 2'd0);
    alloc(5'd9, 2'd0);
    cdb_send(2'd1, 64'h81, 64'h0, 1'b0);
    cdb_send(2'd2, 64'h92, 64'h0, 1'b0);
    vectors++;
    if (commit_valid !== 1'b0) begin
      miscompares++; $display("FAIL br_younger_early got %0b exp 0", commit_valid);
    end
    cdb_send(2'd0, 64'h0, 64'h0, 1'b1);
    repeat (LAT-1) tick();
    vectors++;
    if ({flush, commit_valid, st_commit, dut.count_q} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL br_flush got fl=%0b cv=%0b st=%0b count=%0d exp fl=1 cv=0 st=0 count=0",
               flush, commit_valid, st_commit, dut.count_q);
    end
    alloc_valid = 1'b1; alloc_dest = 5'd11; alloc_kind = 2'd0;
    cdb_valid = 1'b1; cdb_rob_slot = 2'd1; cdb_data = 64'h1;
    tick();
    alloc_valid = 1'b0; cdb_valid = 1'b0;
    vectors++;
    if ({flush, cdb_err, dut.count_q, alloc_slot} !== {1'b0, 1'b0, 3'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL br_flush_cycle got fl=%0b err=%0b count=%0d slot=%0d exp 0 0 0 0",
               flush, cdb_err, dut.count_q, alloc_slot);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (commit_valid !== 1'b0) begin
        miscompares++; $display("FAIL br_squashed_commit cycle %0d got %0b exp 0", i, commit_valid);
      end
    end
  endtask

  task automatic test_err_and_async_reset();
    do_reset();
    cdb_send(2'd2, 64'h5, 64'h0, 1'b0);
    vectors++;
    if (cdb_err !== 1'b1) begin
      miscompares++; $display("FAIL err_empty got %0b exp 1", cdb_err);
    end
    alloc(5'd4, 2'd0);
    cdb_send(2'd0, 64'h77, 64'h0, 1'b0);
    repeat (LAT-1) tick();
    vectors++;
    if ({commit_valid, commit_data, cdb_err} !== {1'b1, 64'h77, 1'b1}) begin
      miscompares++;
      $display("FAIL err_sticky_commit got cv=%0b data=%0h err=%0b exp cv=1 data=77 err=1",
               commit_valid, commit_data, cdb_err);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({commit_valid, commit_dest, commit_data, commit_slot, st_commit, st_addr, st_data,
         flush, cdb_err, full, alloc_slot} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got cv=%0b data=%0h err=%0b slot=%0d exp all 0",
               commit_valid, commit_data, cdb_err, alloc_slot);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0; alloc_dest = '0; alloc_kind = '0;
    cdb_valid = 1'b0; cdb_rob_slot = '0; cdb_data = '0; cdb_addr = '0; cdb_mispredict = 1'b0;
    test_reset();
    test_basic();
    test_order();
    test_full();
    test_store();
    test_branch_flush();
    test_err_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
